// File: rtl/axi_fourchan_tier2_rx_pkg.sv
// rtl/axi_fourchan_tier2_rx_pkg.sv - shared types and constants for the four-channel rx align stage
// Purpose: alignment FSM state type, channel geometry and output-slice offsets.
package axi_fourchan_tier2_rx_pkg;

    localparam int CH_W   = 74;
    localparam int NUM_CH = 4;
    localparam int OUT_W  = CH_W * NUM_CH;

    // Bit offsets of each channel slice inside the concatenated output word.
    localparam int CH0_OFS = 0 * CH_W;
    localparam int CH1_OFS = 1 * CH_W;
    localparam int CH2_OFS = 2 * CH_W;
    localparam int CH3_OFS = 3 * CH_W;

    typedef enum logic [1:0] {
        FLUSH  = 2'd0,
        SEARCH = 2'd1,
        LOCKED = 2'd2
    } rx_state_e;

    function automatic int ch_ofs(input int ch);
        return ch * CH_W;
    endfunction

endpackage

// File: rtl/axi_fourchan_tier2_rx_chfifo.sv
// rtl/axi_fourchan_tier2_rx_chfifo.sv - single-clock per-channel word FIFO with combinational head
// Purpose: DEPTH x CH_W FIFO; flush clears both pointers.
// Ports: clk/rst (sync, active-high), i_flush, i_push/i_data, i_pop,
//        o_head (word at read pointer), o_empty, o_full.
module axi_fourchan_tier2_rx_chfifo
    import axi_fourchan_tier2_rx_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_flush,
    input  logic            i_push,
    input  logic [CH_W-1:0] i_data,
    input  logic            i_pop,
    output logic [CH_W-1:0] o_head,
    output logic            o_empty,
    output logic            o_full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]     r_wr_ptr;
    logic [AW:0]     r_rd_ptr;
    logic [CH_W-1:0] r_mem [DEPTH];

    logic w_do_pop;
    logic w_do_push;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

    assign w_do_pop  = i_pop && !o_empty;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

endmodule

// File: rtl/axi_fourchan_tier2_rx_align.sv
// rtl/axi_fourchan_tier2_rx_align.sv - four-channel receive deskew and alignment stage
// Purpose: buffer each channel, discard words until a marker, then pop all four
//          channels in lockstep into a registered 296-bit output word.
// Ports: clk_wr/rst_wr (sync, active-high), ch0..ch3_rx_data + ch_rx_valid in,
//        rxfifo_rx_data/valid/ready out stream, align_done, sticky align_err/overflow_err.
module axi_fourchan_tier2_rx_align
    import axi_fourchan_tier2_rx_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int MARKER_BIT = 73
) (
    input  logic              clk_wr,
    input  logic              rst_wr,
    input  logic [CH_W-1:0]   ch0_rx_data,
    input  logic [CH_W-1:0]   ch1_rx_data,
    input  logic [CH_W-1:0]   ch2_rx_data,
    input  logic [CH_W-1:0]   ch3_rx_data,
    input  logic [NUM_CH-1:0] ch_rx_valid,
    output logic [OUT_W-1:0]  rxfifo_rx_data,
    output logic              rxfifo_rx_valid,
    input  logic              rxfifo_rx_ready,
    output logic              align_done,
    output logic              align_err,
    output logic              overflow_err
);

    rx_state_e r_state;
    rx_state_e w_next_state;

    logic [OUT_W-1:0] r_out_data;
    logic             r_out_valid;
    logic             r_align_done;
    logic             r_align_err;
    logic             r_ovf_err;

    logic [CH_W-1:0]   w_ch_data [NUM_CH];
    logic [CH_W-1:0]   w_head    [NUM_CH];
    logic [NUM_CH-1:0] w_empty;
    logic [NUM_CH-1:0] w_full;
    logic [NUM_CH-1:0] w_mark;
    logic [NUM_CH-1:0] w_push;
    logic [NUM_CH-1:0] w_pop;
    logic              w_flush;
    logic              w_all_ne;
    logic              w_slot_free;
    logic              w_load;
    logic              w_mismatch;
    logic              w_ovf;
    logic [OUT_W-1:0]  w_cat;

    assign w_ch_data[0] = ch0_rx_data;
    assign w_ch_data[1] = ch1_rx_data;
    assign w_ch_data[2] = ch2_rx_data;
    assign w_ch_data[3] = ch3_rx_data;

    assign w_flush     = (r_state == FLUSH);
    assign w_push      = w_flush ? '0 : ch_rx_valid;
    assign w_all_ne    = &(~w_empty);
    assign w_slot_free = !r_out_valid || rxfifo_rx_ready;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        axi_fourchan_tier2_rx_chfifo #(
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk_wr),
            .rst     (rst_wr),
            .i_flush (w_flush),
            .i_push  (w_push[g]),
            .i_data  (w_ch_data[g]),
            .i_pop   (w_pop[g]),
            .o_head  (w_head[g]),
            .o_empty (w_empty[g]),
            .o_full  (w_full[g])
        );
        assign w_mark[g] = w_head[g][MARKER_BIT];
    end

    always_comb begin
        w_cat = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            w_cat[ch_ofs(n) +: CH_W] = w_head[n];
        end
    end

    always_ff @(posedge clk_wr) begin
        if (rst_wr) r_state <= FLUSH;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_pop        = '0;
        w_load       = 1'b0;
        w_mismatch   = 1'b0;
        case (r_state)
            FLUSH: begin
                w_next_state = SEARCH;
            end
            SEARCH: begin
                // Lock is taken without popping so the marker words are forwarded first.
                if (w_all_ne && (&w_mark)) begin
                    w_next_state = LOCKED;
                end else begin
                    w_pop = ~w_empty & ~w_mark;
                end
            end
            LOCKED: begin
                if (w_all_ne && w_slot_free) begin
                    w_pop = '1;
                    if ((&w_mark) || !(|w_mark)) begin
                        w_load = 1'b1;
                    end else begin
                        w_mismatch   = 1'b1;
                        w_next_state = FLUSH;
                    end
                end
            end
            default: begin
                w_next_state = FLUSH;
            end
        endcase
        w_ovf = |(w_push & w_full & ~w_pop);
        if (w_ovf) w_next_state = FLUSH;
    end

    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_align_done <= 1'b0;
            r_align_err  <= 1'b0;
            r_ovf_err    <= 1'b0;
        end else begin
            r_align_done <= (r_state == LOCKED);
            if (w_mismatch) r_align_err <= 1'b1;
            if (w_ovf)      r_ovf_err   <= 1'b1;
            // A held word survives leaving LOCKED until it is accepted.
            if (w_load) begin
                r_out_data  <= w_cat;
                r_out_valid <= 1'b1;
            end else if (rxfifo_rx_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign rxfifo_rx_data  = r_out_data;
    assign rxfifo_rx_valid = r_out_valid;
    assign align_done      = r_align_done;
    assign align_err       = r_align_err;
    assign overflow_err    = r_ovf_err;

endmodule

// File: tb/tb_axi_fourchan_tier2_rx_align.sv
// tb/tb_axi_fourchan_tier2_rx_align.sv - directed self-checking bench for the rx align stage
module tb_axi_fourchan_tier2_rx_align;
    import axi_fourchan_tier2_rx_pkg::*;

    localparam int DEPTH = 8;
    localparam logic [73:0] MK = 74'h2000000000000000001;

    logic         clk_wr = 1'b0;
    logic         rst_wr = 1'b1;
    logic [73:0]  ch0_rx_data = '0;
    logic [73:0]  ch1_rx_data = '0;
    logic [73:0]  ch2_rx_data = '0;
    logic [73:0]  ch3_rx_data = '0;
    logic [3:0]   ch_rx_valid = '0;
    logic [295:0] rxfifo_rx_data;
    logic         rxfifo_rx_valid;
    logic         rxfifo_rx_ready = 1'b1;
    logic         align_done;
    logic         align_err;
    logic         overflow_err;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk_wr = ~clk_wr;

    axi_fourchan_tier2_rx_align #(
        .DEPTH      (DEPTH),
        .MARKER_BIT (73)
    ) dut (
        .clk_wr          (clk_wr),
        .rst_wr          (rst_wr),
        .ch0_rx_data     (ch0_rx_data),
        .ch1_rx_data     (ch1_rx_data),
        .ch2_rx_data     (ch2_rx_data),
        .ch3_rx_data     (ch3_rx_data),
        .ch_rx_valid     (ch_rx_valid),
        .rxfifo_rx_data  (rxfifo_rx_data),
        .rxfifo_rx_valid (rxfifo_rx_valid),
        .rxfifo_rx_ready (rxfifo_rx_ready),
        .align_done      (align_done),
        .align_err       (align_err),
        .overflow_err    (overflow_err)
    );

    task automatic chk(input string tag, input logic [295:0] got, input logic [295:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_wr);
        #1;
    endtask

    function automatic logic [295:0] cat4(input logic [73:0] c0, input logic [73:0] c1,
                                          input logic [73:0] c2, input logic [73:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    task automatic push4(input logic [73:0] d0, input logic [73:0] d1,
                         input logic [73:0] d2, input logic [73:0] d3, input logic [3:0] v);
        ch0_rx_data = d0;
        ch1_rx_data = d1;
        ch2_rx_data = d2;
        ch3_rx_data = d3;
        ch_rx_valid = v;
        step();
        ch_rx_valid = '0;
    endtask

    // Leaves the block in SEARCH: two reset edges, then the FLUSH edge.
    task automatic do_reset();
        rst_wr = 1'b1;
        step();
        step();
        rst_wr = 1'b0;
        step();
    endtask

    // Waits (bounded) for a valid word, checks it, and lets it be accepted when ready is high.
    task automatic expect_word(input string tag, input logic [295:0] exp);
        int n;
        n = 0;
        while (!rxfifo_rx_valid && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, 296'(rxfifo_rx_valid), 296'(1));
        chk(tag, rxfifo_rx_data, exp);
        if (rxfifo_rx_ready) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        // Reset state
        rst_wr = 1'b1;
        step();
        chk("rst_valid", 296'(rxfifo_rx_valid), 296'(0));
        chk("rst_data", rxfifo_rx_data, 296'(0));
        chk("rst_done", 296'(align_done), 296'(0));
        chk("rst_aerr", 296'(align_err), 296'(0));
        chk("rst_oerr", 296'(overflow_err), 296'(0));
        chk("rst_state", 296'(dut.r_state), 296'(FLUSH));
        step();
        rst_wr = 1'b0;
        step();
        chk("post_flush_state", 296'(dut.r_state), 296'(SEARCH));

        // Basic lock: marker on all channels, then 0x5
        rxfifo_rx_ready = 1'b1;
        push4(MK, MK, MK, MK, 4'hF);
        push4(74'h5, 74'h5, 74'h5, 74'h5, 4'hF);
        chk("basic_state", 296'(dut.r_state), 296'(LOCKED));
        expect_word("basic_mk", cat4(MK, MK, MK, MK));
        chk("basic_done", 296'(align_done), 296'(1));
        expect_word("basic_d5", cat4(74'h5, 74'h5, 74'h5, 74'h5));
        chk("basic_drained", 296'(rxfifo_rx_valid), 296'(0));

        // Skew: ch2 sees 0x11, 0x12 before its marker
        do_reset();
        push4(MK + 74'd0, MK + 74'd1, 74'h11,      MK + 74'd3, 4'hF);
        push4(74'h20,     74'h21,     74'h12,      74'h23,     4'hF);
        push4(74'h30,     74'h31,     MK + 74'd2,  74'h33,     4'hF);
        push4(74'h0,      74'h0,      74'h22,      74'h0,      4'h4);
        push4(74'h0,      74'h0,      74'h32,      74'h0,      4'h4);
        expect_word("skew_mk", cat4(MK + 74'd0, MK + 74'd1, MK + 74'd2, MK + 74'd3));
        expect_word("skew_w1", cat4(74'h20, 74'h21, 74'h22, 74'h23));
        expect_word("skew_w2", cat4(74'h30, 74'h31, 74'h32, 74'h33));
        chk("skew_aerr", 296'(align_err), 296'(0));

        // Backpressure: ready low while marker + 6 words arrive
        do_reset();
        rxfifo_rx_ready = 1'b0;
        push4(MK, MK, MK, MK, 4'hF);
        for (int k = 0; k < 6; k++) begin
            push4(74'(8'h40 + 4 * k), 74'(8'h41 + 4 * k), 74'(8'h42 + 4 * k), 74'(8'h43 + 4 * k), 4'hF);
        end
        step();
        step();
        step();
        chk("bp_hold_valid", 296'(rxfifo_rx_valid), 296'(1));
        chk("bp_hold_data", rxfifo_rx_data, cat4(MK, MK, MK, MK));
        chk("bp_no_ovf", 296'(overflow_err), 296'(0));
        rxfifo_rx_ready = 1'b1;
        expect_word("bp_mk", cat4(MK, MK, MK, MK));
        for (int k = 0; k < 6; k++) begin
            expect_word($sformatf("bp_w%0d", k),
                        cat4(74'(8'h40 + 4 * k), 74'(8'h41 + 4 * k), 74'(8'h42 + 4 * k), 74'(8'h43 + 4 * k)));
        end
        chk("bp_drained", 296'(rxfifo_rx_valid), 296'(0));

        // Overflow: DEPTH+2 marker words into ch0 only
        do_reset();
        rxfifo_rx_ready = 1'b0;
        for (int k = 0; k < DEPTH + 2; k++) begin
            push4(MK | 74'(k), 74'h0, 74'h0, 74'h0, 4'h1);
            if (k == DEPTH - 1) chk("ovf_not_yet", 296'(overflow_err), 296'(0));
            if (k == DEPTH) begin
                chk("ovf_flag", 296'(overflow_err), 296'(1));
                chk("ovf_flush", 296'(dut.r_state), 296'(FLUSH));
            end
            if (k == DEPTH + 1) chk("ovf_search", 296'(dut.r_state), 296'(SEARCH));
        end
        step();
        step();
        chk("ovf_sticky", 296'(overflow_err), 296'(1));
        chk("ovf_no_out", 296'(rxfifo_rx_valid), 296'(0));

        // Mismatch: ch1 head carries a marker while others carry data
        do_reset();
        rxfifo_rx_ready = 1'b1;
        push4(MK + 74'd0, MK + 74'd1, MK + 74'd2, MK + 74'd3, 4'hF);
        push4(74'h50, MK + 74'h61, 74'h52, 74'h53, 4'hF);
        expect_word("mm_mk", cat4(MK + 74'd0, MK + 74'd1, MK + 74'd2, MK + 74'd3));
        chk("mm_aerr", 296'(align_err), 296'(1));
        chk("mm_no_out", 296'(rxfifo_rx_valid), 296'(0));
        chk("mm_flush", 296'(dut.r_state), 296'(FLUSH));
        step();
        chk("mm_done_fell", 296'(align_done), 296'(0));
        chk("mm_search", 296'(dut.r_state), 296'(SEARCH));
        push4(MK + 74'h70, MK + 74'h71, MK + 74'h72, MK + 74'h73, 4'hF);
        push4(74'h80, 74'h81, 74'h82, 74'h83, 4'hF);
        expect_word("mm_relock_mk", cat4(MK + 74'h70, MK + 74'h71, MK + 74'h72, MK + 74'h73));
        expect_word("mm_relock_w", cat4(74'h80, 74'h81, 74'h82, 74'h83));
        chk("mm_relock_done", 296'(align_done), 296'(1));
        chk("mm_aerr_sticky", 296'(align_err), 296'(1));

        // Reset mid-burst with words queued and output held
        rxfifo_rx_ready = 1'b0;
        push4(74'h90, 74'h91, 74'h92, 74'h93, 4'hF);
        push4(74'hA0, 74'hA1, 74'hA2, 74'hA3, 4'hF);
        push4(74'hB0, 74'hB1, 74'hB2, 74'hB3, 4'hF);
        chk("mid_held", rxfifo_rx_data, cat4(74'h90, 74'h91, 74'h92, 74'h93));
        rst_wr = 1'b1;
        step();
        chk("mid_rst_valid", 296'(rxfifo_rx_valid), 296'(0));
        chk("mid_rst_data", rxfifo_rx_data, 296'(0));
        chk("mid_rst_done", 296'(align_done), 296'(0));
        chk("mid_rst_aerr", 296'(align_err), 296'(0));
        chk("mid_rst_oerr", 296'(overflow_err), 296'(0));
        chk("mid_rst_state", 296'(dut.r_state), 296'(FLUSH));
        rst_wr = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
